// File: rtl/demux1x4_stream.sv
// 1-to-4 N-bit stream demultiplexer with per-lane one-word holding registers.
// Routes by explicit select or by a strict-order round-robin pointer.
module demux1x4_stream #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_sel,
    input  logic         in_auto,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] y0,
    output logic [N-1:0] y1,
    output logic [N-1:0] y2,
    output logic [N-1:0] y3,
    output logic [3:0]   out_valid,
    input  logic [3:0]   out_ready,
    output logic [1:0]   rr_ptr,
    output logic         busy
);

    logic [N-1:0] ydata [4];
    logic [1:0]   tgt;
    logic         accept;
    logic [3:0]   load;

    always_comb begin
        tgt      = in_auto ? rr_ptr : in_sel;
        in_ready = !rst && (!out_valid[tgt] || out_ready[tgt]);
        accept   = in_valid && in_ready;
        load     = accept ? (4'b0001 << tgt) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            rr_ptr    <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                ydata[k] <= '0;
            end
        end else begin
            // A load on a draining lane wins, so the lane stays valid with the new word.
            out_valid <= (out_valid & ~out_ready) | load;
            for (int unsigned k = 0; k < 4; k++) begin
                if (load[k]) begin
                    ydata[k] <= in_data;
                end
            end
            if (accept && in_auto) begin
                rr_ptr <= rr_ptr + 2'd1;
            end
        end
    end

    assign y0   = ydata[0];
    assign y1   = ydata[1];
    assign y2   = ydata[2];
    assign y3   = ydata[3];
    assign busy = |out_valid;

endmodule

// File: tb/tb_demux1x4_stream.sv
// Directed table-driven bench for demux1x4_stream (N=8); expected values hand-computed.
module tb_demux1x4_stream;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] in_data;
    logic [1:0]   in_sel;
    logic         in_auto;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] y0, y1, y2, y3;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [1:0]   rr_ptr;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;

    demux1x4_stream #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_auto   (in_auto),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y0        (y0),
        .y1        (y1),
        .y2        (y2),
        .y3        (y3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [7:0]  d;
        logic [1:0]  sel;
        logic        au;
        logic        v;
        logic [3:0]  ordy;
        logic        rdy;   // in_ready before the edge
        logic [3:0]  ov;    // out_valid after the edge
        logic [31:0] y;     // {y3,y2,y1,y0} after the edge
        logic [1:0]  ptr;   // rr_ptr after the edge
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; in_ready is checked
    // before the next edge and registered outputs 1 unit after it.
    task automatic run_vec(input vec_t t, input string tag);
        rst       = t.r;
        in_data   = t.d;
        in_sel    = t.sel;
        in_auto   = t.au;
        in_valid  = t.v;
        out_ready = t.ordy;
        #1;
        chk({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, t.rdy});
        @(posedge clk);
        #1;
        chk({tag, ".out_valid"}, {28'd0, out_valid}, {28'd0, t.ov});
        chk({tag, ".y"}, {y3, y2, y1, y0}, t.y);
        chk({tag, ".rr_ptr"}, {30'd0, rr_ptr}, {30'd0, t.ptr});
        chk({tag, ".busy"}, {31'd0, busy}, {31'd0, |t.ov});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //            r  d      sel   au    v     ordy     rdy   ov       y             ptr
        tbl[0]  = '{1'b0, 8'h11, 2'd0, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0001, 32'h00000011, 2'd0};
        tbl[1]  = '{1'b0, 8'h22, 2'd1, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h00002211, 2'd0};
        tbl[2]  = '{1'b0, 8'h33, 2'd2, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h00332211, 2'd0};
        tbl[3]  = '{1'b0, 8'h44, 2'd3, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b1000, 32'h44332211, 2'd0};
        tbl[4]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h44332211, 2'd0};
        tbl[5]  = '{1'b0, 8'hA5, 2'd2, 1'b0, 1'b1, 4'b1011, 1'b1, 4'b0100, 32'h44A52211, 2'd0};
        tbl[6]  = '{1'b0, 8'h5A, 2'd2, 1'b0, 1'b1, 4'b1011, 1'b0, 4'b0100, 32'h44A52211, 2'd0};
        tbl[7]  = '{1'b0, 8'h5A, 2'd2, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h445A2211, 2'd0};
        tbl[8]  = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h445A2211, 2'd0};
        tbl[9]  = '{1'b0, 8'h01, 2'd3, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 32'h445A2201, 2'd1};
        tbl[10] = '{1'b0, 8'h02, 2'd3, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h445A0201, 2'd2};
        tbl[11] = '{1'b0, 8'h03, 2'd3, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h44030201, 2'd3};
        tbl[12] = '{1'b0, 8'h04, 2'd3, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1000, 32'h04030201, 2'd0};
        tbl[13] = '{1'b0, 8'h05, 2'd3, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 32'h04030205, 2'd1};
        tbl[14] = '{1'b0, 8'h06, 2'd3, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h04030605, 2'd2};
        tbl[15] = '{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h04030605, 2'd2};

        // Reset
        rst = 1'b1; in_data = '0; in_sel = '0; in_auto = 1'b0; in_valid = 1'b1; out_ready = 4'b1111;
        @(posedge clk); #1;
        chk("reset.in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("reset.out_valid", {28'd0, out_valid}, 32'd0);
        chk("reset.y", {y3, y2, y1, y0}, 32'd0);
        chk("reset.rr_ptr", {30'd0, rr_ptr}, 32'd0);
        chk("reset.busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 16; i++) begin
            run_vec(tbl[i], $sformatf("tbl%0d", i));
        end

        // Auto stall: fill y1 while steering the pointer back to 01, lane 1 not ready
        run_vec('{1'b0, 8'h07, 2'd0, 1'b1, 1'b1, 4'b1101, 1'b1, 4'b0100, 32'h04070605, 2'd3}, "stall_a");
        run_vec('{1'b0, 8'h08, 2'd0, 1'b1, 1'b1, 4'b1101, 1'b1, 4'b1000, 32'h08070605, 2'd0}, "stall_b");
        run_vec('{1'b0, 8'h09, 2'd0, 1'b1, 1'b1, 4'b1101, 1'b1, 4'b0001, 32'h08070609, 2'd1}, "stall_c");
        run_vec('{1'b0, 8'h0A, 2'd1, 1'b0, 1'b1, 4'b1101, 1'b1, 4'b0010, 32'h08070A09, 2'd1}, "stall_d");
        run_vec('{1'b0, 8'h0B, 2'd0, 1'b1, 1'b1, 4'b1101, 1'b0, 4'b0010, 32'h08070A09, 2'd1}, "stall_e");
        run_vec('{1'b0, 8'h0B, 2'd0, 1'b1, 1'b1, 4'b1101, 1'b0, 4'b0010, 32'h08070A09, 2'd1}, "stall_f");
        run_vec('{1'b0, 8'h0B, 2'd0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 32'h08070B09, 2'd2}, "stall_rel");

        // Mixed mode: fixed accept keeps the pointer, next auto word goes to y2
        run_vec('{1'b0, 8'h77, 2'd0, 1'b0, 1'b1, 4'b1111, 1'b1, 4'b0001, 32'h08070B77, 2'd2}, "mixed_fix");
        run_vec('{1'b0, 8'h78, 2'd0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 32'h08780B77, 2'd3}, "mixed_auto");

        // Reset mid-stall with out_valid=1011
        run_vec('{1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 32'h08780B77, 2'd3}, "rs_drain");
        run_vec('{1'b0, 8'h81, 2'd0, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0001, 32'h08780B81, 2'd3}, "rs_f0");
        run_vec('{1'b0, 8'h82, 2'd1, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0011, 32'h08788281, 2'd3}, "rs_f1");
        run_vec('{1'b0, 8'h83, 2'd3, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b1011, 32'h83788281, 2'd3}, "rs_f3");
        run_vec('{1'b1, 8'h99, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0000, 32'h00000000, 2'd0}, "rs_rst");
        run_vec('{1'b0, 8'h99, 2'd2, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0100, 32'h00990000, 2'd0}, "rs_resume");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
